sop_sweep_ctrl: RTL and testbench

- Sequencer that drives an external 4-input combinational function unit (for example, the NAND-NAND sum-of-products block) through all 16 input combinations.
- Samples the unit's output for each combination and assembles the 16-bit truth table.
- Compares the table against an expected table latched at start and reports pass/fail, first mismatch index and ones count.
- Sits between a test/config master (start/done handshake) and one shared function-unit instance.

---
 rtl/sop_sweep_ctrl_if.sv | 29 ++
 rtl/sop_sweep_ctrl.sv | 102 ++++++++++
 tb/tb_sop_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sop_sweep_ctrl_if.sv
// Handshake and function-unit signals between a test master,
// the sweep controller and the shared 4-input function unit.
interface sop_sweep_ctrl_if;
  logic        start;
  logic [15:0] expected;
  logic        f_out;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  mismatch_idx;
  logic [4:0]  ones_count;
  logic [15:0] table_out;

  modport slave (
    input  start, expected, f_out,
    output a, b, c, d, busy, done, pass,
    output mismatch_idx, ones_count, table_out
  );

  modport master (
    output start, expected, f_out,
    input  a, b, c, d, busy, done, pass,
    input  mismatch_idx, ones_count, table_out
  );
endinterface

// File: rtl/sop_sweep_ctrl.sv
// Walks a 4-input function unit through all 16 vectors, captures
// its truth table and compares it against a latched expectation.
module sop_sweep_ctrl #(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  sop_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_midx;
  logic [15:0] r_exp;
  logic [15:0] r_tbl;
  logic [4:0]  r_ones;
  logic        r_fail;
  logic        r_pass;
  logic        w_miss;
  logic        w_stop;

  assign w_miss = (bus.f_out != r_exp[r_idx]);
  assign w_stop = (r_idx == 4'd15) || (STOP_ON_FAIL && w_miss);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == SET_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_stop ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
      r_midx  <= 4'd0;
      r_exp   <= 16'd0;
      r_tbl   <= 16'd0;
      r_ones  <= 5'd0;
      r_fail  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_exp  <= bus.expected;
            r_idx  <= 4'd0;
            r_cnt  <= 4'd0;
            r_midx <= 4'd0;
            r_tbl  <= 16'd0;
            r_ones <= 5'd0;
            r_fail <= 1'b0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt + 4'd1;
        S_SAMPLE: begin
          r_tbl[r_idx] <= bus.f_out;
          r_ones       <= r_ones + {4'd0, bus.f_out};
          // only the first mismatch is reported
          if (w_miss && !r_fail) begin
            r_midx <= r_idx;
            r_fail <= 1'b1;
          end
          if (!w_stop) begin
            r_idx <= r_idx + 4'd1;
            r_cnt <= 4'd0;
          end
        end
        S_DONE:  r_pass <= ~r_fail;
        default: ;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = r_idx;
  assign bus.busy         = (r_state == S_SETTLE) ||
                            (r_state == S_SAMPLE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.pass         = r_pass;
  assign bus.mismatch_idx = r_midx;
  assign bus.ones_count   = r_ones;
  assign bus.table_out    = r_tbl;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Bench for sop_sweep_ctrl: three instances (full, early-stop,
// slow settle) against a truth-table level reference model.
module tb_sop_sweep_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        start_s [3];
  logic [15:0] exp_s   [3];
  logic [15:0] fn_s    [3];
  logic        done_o  [3];
  logic        busy_o  [3];
  logic        pass_o  [3];
  logic [3:0]  vec_o   [3];
  logic [3:0]  midx_o  [3];
  logic [4:0]  ones_o  [3];
  logic [15:0] tbl_o   [3];

  sop_sweep_ctrl_if ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : gu
    logic [3:0] w_v;
    assign w_v = {ifs[g].a, ifs[g].b, ifs[g].c, ifs[g].d};
    assign ifs[g].start    = start_s[g];
    assign ifs[g].expected = exp_s[g];
    assign ifs[g].f_out    = fn_s[g][w_v];
    assign done_o[g] = ifs[g].done;
    assign busy_o[g] = ifs[g].busy;
    assign pass_o[g] = ifs[g].pass;
    assign vec_o[g]  = w_v;
    assign midx_o[g] = ifs[g].mismatch_idx;
    assign ones_o[g] = ifs[g].ones_count;
    assign tbl_o[g]  = ifs[g].table_out;

    sop_sweep_ctrl #(
      .SETTLE      ((g == 2) ? 3 : 1),
      .STOP_ON_FAIL(g == 1)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifs[g].slave)
    );
  end

  function automatic int settle_of(input int u);
    return (u == 2) ? 3 : 1;
  endfunction

  // Truth-table view of the sweep outcome.
  function automatic void model(
    input  logic [15:0] fn, ex,
    input  bit          stop,
    input  int          s,
    output logic [15:0] tbl,
    output logic [4:0]  ones,
    output logic        pass,
    output logic [3:0]  midx,
    output int          lat
  );
    logic [15:0] diff;
    int last;
    diff = fn ^ ex;
    last = 15;
    midx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (diff[i]) midx = 4'(i);
    pass = (diff == 16'd0);
    if (stop && !pass) last = int'(midx);
    tbl = 16'd0;
    for (int i = 0; i <= last; i++) tbl[i] = fn[i];
    ones = 5'($countones(tbl));
    lat = (last + 1) * (s + 1) + 1;
  endfunction

  function automatic logic [15:0] sop_table();
    logic [15:0] t;
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[i] = (v[3] & v[1]) | (v[2] & v[0]);
    end
    return t;
  endfunction

  // Runs one sweep; lat counts edges from start-accept to the
  // edge at which done is seen high.
  task automatic sweep(
    input  int          u,
    input  logic [15:0] fn, ex,
    input  int          poke,
    output int          lat,
    output int          nd,
    output int          verr
  );
    int s;
    int cnt;
    int e;
    s = settle_of(u);
    cnt = 0;
    fn_s[u] = fn;
    exp_s[u] = ex;
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
    exp_s[u] = ~ex;
    lat = -1;
    nd = 0;
    verr = 0;
    while (cnt < 160 && (lat < 0 || cnt < lat + 3)) begin
      e = cnt / (s + 1);
      if (e > 15) e = 15;
      if (lat < 0 && !done_o[u] && vec_o[u] != 4'(e)) verr++;
      if (done_o[u]) begin
        nd++;
        if (lat < 0) lat = cnt + 1;
      end
      start_s[u] = (cnt == poke);
      @(negedge clk);
      cnt++;
    end
    start_s[u] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if ({busy_o[u], done_o[u], pass_o[u], midx_o[u],
           ones_o[u], tbl_o[u], vec_o[u]} !== 31'd0) begin
        bad++;
        $display("FAIL reset_u%0d got busy=%b done=%b pass=%b tbl=%h vec=%h want all 0",
                 u, busy_o[u], done_o[u], pass_o[u], tbl_o[u], vec_o[u]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known();
    logic [15:0] mt; logic [4:0] mo; logic mp; logic [3:0] mi;
    int ml, lat, nd, verr;
    model(sop_table(), 16'hECA0, 1'b0, 1, mt, mo, mp, mi, ml);
    sweep(0, sop_table(), 16'hECA0, -1, lat, nd, verr);
    total++;
    if (lat !== ml) begin bad++;
      $display("FAIL known_lat got=%0d want=%0d", lat, ml); end
    total++;
    if (tbl_o[0] !== mt || ones_o[0] !== mo) begin bad++;
      $display("FAIL known_tbl got=%h/%0d want=%h/%0d",
               tbl_o[0], ones_o[0], mt, mo); end
    total++;
    if (pass_o[0] !== mp) begin bad++;
      $display("FAIL known_pass got=%b want=%b", pass_o[0], mp); end
    total++;
    if (verr !== 0 || nd !== 1) begin bad++;
      $display("FAIL known_vec got verr=%0d nd=%0d want 0/1", verr, nd); end
  endtask

  task automatic test_mismatch_full();
    int lat, nd, verr;
    sweep(0, sop_table(), 16'hECA1, -1, lat, nd, verr);
    total++;
    if ({pass_o[0], midx_o[0]} !== 5'b0_0000 || lat !== 33) begin bad++;
      $display("FAIL mism_full got pass=%b idx=%0d lat=%0d want 0/0/33",
               pass_o[0], midx_o[0], lat); end
    total++;
    if (tbl_o[0] !== 16'hECA0 || ones_o[0] !== 5'd7) begin bad++;
      $display("FAIL mism_tbl got=%h/%0d want ECA0/7", tbl_o[0], ones_o[0]); end
  endtask

  task automatic test_early_stop();
    int lat, nd, verr;
    sweep(1, sop_table(), 16'hE8A0, -1, lat, nd, verr);
    total++;
    if (lat !== 23) begin bad++;
      $display("FAIL stop_lat got=%0d want=23", lat); end
    total++;
    if (pass_o[1] !== 1'b0 || midx_o[1] !== 4'd10) begin bad++;
      $display("FAIL stop_idx got pass=%b idx=%0d want 0/10",
               pass_o[1], midx_o[1]); end
    total++;
    if (tbl_o[1] !== 16'h04A0 || ones_o[1] !== 5'd3) begin bad++;
      $display("FAIL stop_tbl got=%h/%0d want 04A0/3", tbl_o[1], ones_o[1]); end
  endtask

  task automatic test_no_wrap();
    int lat, nd, verr;
    sweep(2, 16'hFFFF, 16'hFFFF, -1, lat, nd, verr);
    total++;
    if (ones_o[2] !== 5'd16 || pass_o[2] !== 1'b1) begin bad++;
      $display("FAIL nowrap got ones=%0d pass=%b want 16/1",
               ones_o[2], pass_o[2]); end
    total++;
    if (lat !== 65 || verr !== 0) begin bad++;
      $display("FAIL nowrap_lat got=%0d verr=%0d want 65/0", lat, verr); end
  endtask

  task automatic test_ignored_start();
    int lat, nd, verr;
    sweep(0, sop_table(), 16'hECA0, 5, lat, nd, verr);
    total++;
    if (nd !== 1 || lat !== 33) begin bad++;
      $display("FAIL ignore_start got nd=%0d lat=%0d want 1/33", nd, lat); end
  endtask

  task automatic test_reset_mid();
    int nd, lat, verr;
    fn_s[0] = sop_table();
    exp_s[0] = 16'hECA0;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy_o[0], done_o[0], vec_o[0], tbl_o[0], pass_o[0]} !== 23'd0) begin
      bad++;
      $display("FAIL rst_mid got busy=%b vec=%h tbl=%h want 0/0/0",
               busy_o[0], vec_o[0], tbl_o[0]);
    end
    nd = 0;
    repeat (40) begin
      if (done_o[0]) nd++;
      @(negedge clk);
    end
    total++;
    if (nd !== 0) begin bad++;
      $display("FAIL rst_nodone got=%0d want=0", nd); end
    sweep(0, sop_table(), 16'hECA0, -1, lat, nd, verr);
    total++;
    if (lat !== 33 || tbl_o[0] !== 16'hECA0 || pass_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_resweep got lat=%0d tbl=%h pass=%b want 33/ECA0/1",
               lat, tbl_o[0], pass_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, d1, d2;
    fn_s[0] = sop_table();
    exp_s[0] = 16'hECA1;
    start_s[0] = 1'b1;
    @(negedge clk);
    cnt = 0; d1 = -1; d2 = -1;
    while (cnt < 200 && d2 < 0) begin
      if (done_o[0]) begin
        if (d1 < 0) d1 = cnt;
        else d2 = cnt;
      end
      if (d2 < 0) begin
        @(negedge clk);
        cnt++;
      end
    end
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    // one DONE cycle plus one IDLE cycle separate the sweeps
    total++;
    if (d1 !== 32 || d2 - d1 !== 34) begin bad++;
      $display("FAIL b2b got d1=%0d gap=%0d want 32/34", d1, d2 - d1); end
    total++;
    if (pass_o[0] !== 1'b0 || tbl_o[0] !== 16'hECA0 || busy_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_res got pass=%b tbl=%h busy=%b want 0/ECA0/0",
               pass_o[0], tbl_o[0], busy_o[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] fn, ex, mt; logic [4:0] mo; logic mp; logic [3:0] mi;
    int ml, lat, nd, verr, mode;
    for (int it = 0; it < 12; it++) begin
      int u;
      u = it % 3;
      fn = 16'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) ex = fn;
      else if (mode == 1) ex = fn ^ (16'd1 << $urandom_range(0, 15));
      else ex = 16'($urandom);
      model(fn, ex, u == 1, settle_of(u), mt, mo, mp, mi, ml);
      sweep(u, fn, ex, -1, lat, nd, verr);
      total++;
      if (tbl_o[u] !== mt || ones_o[u] !== mo || pass_o[u] !== mp) begin
        bad++;
        $display("FAIL rnd_u%0d fn=%h ex=%h got %h/%0d/%b want %h/%0d/%b",
                 u, fn, ex, tbl_o[u], ones_o[u], pass_o[u], mt, mo, mp);
      end
      total++;
      if (!mp && midx_o[u] !== mi) begin bad++;
        $display("FAIL rnd_idx_u%0d got=%0d want=%0d", u, midx_o[u], mi); end
      total++;
      if (lat !== ml || nd !== 1 || verr !== 0) begin bad++;
        $display("FAIL rnd_lat_u%0d got lat=%0d nd=%0d verr=%0d want %0d/1/0",
                 u, lat, nd, verr, ml);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0;
      exp_s[u] = 16'd0;
      fn_s[u] = 16'd0;
    end
    test_reset();
    test_known();
    test_mismatch_full();
    test_early_stop();
    test_no_wrap();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
